// File: rtl/fb_pkg.sv
// Shared types and parameter helpers for the framebuffer write path.
package fb_pkg;

  typedef enum logic [0:0] {
    S_WAIT   = 1'b0,
    S_ACTIVE = 1'b1
  } fb_state_e;

  function automatic int words_per_line(input int fb_width, input int data_width);
    return fb_width / data_width;
  endfunction

  // The window must tile into whole words, fit the RAM, and end below counter saturation.
  function automatic bit params_legal(input int aw, input int dw, input int fbw,
                                      input int fbh, input int xo, input int yo,
                                      input int cw);
    return (dw >= 2) && (fbw >= dw) && (fbw % dw == 0) && (fbh >= 1) &&
           (aw >= 1) && (aw < 31) && (cw >= 1) && (cw < 31) &&
           (xo >= 0) && (yo >= 0) &&
           (longint'(fbw / dw) * longint'(fbh) <= (longint'(1) << aw)) &&
           (longint'(xo + fbw) < (longint'(1) << cw)) &&
           (longint'(yo + fbh) < (longint'(1) << cw));
  endfunction

endpackage

// File: rtl/fb_pixel_packer.sv
// MSB-first serial-to-parallel packer; word_valid_o fires combinationally on the last bit of a word.
module fb_pixel_packer #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear_i,
  input  logic                  shift_i,
  input  logic                  pixel_i,
  output logic                  word_valid_o,
  output logic [DATA_WIDTH-1:0] word_o
);

  localparam int CNT_W = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

  logic [DATA_WIDTH-2:0] sreg_q, sreg_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  assign word_o       = {sreg_q, pixel_i};
  assign word_valid_o = shift_i && (cnt_q == CNT_LAST);

  always_comb begin
    sreg_d = sreg_q;
    cnt_d  = cnt_q;
    if (clear_i) begin
      sreg_d = '0;
      cnt_d  = '0;
    end else if (shift_i) begin
      sreg_d = word_o[DATA_WIDTH-2:0];
      cnt_d  = word_valid_o ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sreg_q <= '0;
      cnt_q  <= '0;
    end else begin
      sreg_q <= sreg_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/fb_writer.sv
// Crops a window from a 1bpp video stream, packs it into words and drives the framebuffer write port.
module fb_writer
  import fb_pkg::*;
#(
  parameter int ADDR_WIDTH  = 13,
  parameter int DATA_WIDTH  = 8,
  parameter int FB_WIDTH    = 256,
  parameter int FB_HEIGHT   = 256,
  parameter int X_OFFSET    = 0,
  parameter int Y_OFFSET    = 0,
  parameter int COUNT_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  vsync,
  input  logic                  de,
  input  logic                  pixel,
  output logic                  wr_enable,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  frame_done,
  output logic                  busy
);

  localparam int WORDS_PER_LINE = words_per_line(FB_WIDTH, DATA_WIDTH);
  localparam int X_END  = X_OFFSET + FB_WIDTH;
  localparam int Y_END  = Y_OFFSET + FB_HEIGHT;
  localparam logic [ADDR_WIDTH-1:0]  ROW_STEP = ADDR_WIDTH'(WORDS_PER_LINE);
  localparam logic [COUNT_WIDTH-1:0] Y_LAST   = COUNT_WIDTH'(Y_END - 1);

  generate
    if (!params_legal(ADDR_WIDTH, DATA_WIDTH, FB_WIDTH, FB_HEIGHT,
                      X_OFFSET, Y_OFFSET, COUNT_WIDTH)) begin : g_bad_params
      $error("fb_writer: illegal window/width parameter combination");
    end
  endgenerate

  fb_state_e state_q, state_d;
  logic vsync_prev_q, de_prev_q;
  logic [COUNT_WIDTH-1:0] x_q, x_d, y_q, y_d;
  logic [ADDR_WIDTH-1:0]  row_base_q, row_base_d, word_idx_q, word_idx_d;
  logic                   wr_enable_q, wr_enable_d;
  logic [ADDR_WIDTH-1:0]  wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0]  wr_data_q, wr_data_d;
  logic                   frame_done_q, frame_done_d;

  logic vs_rise, de_fall, active, in_x, in_y, take_px, line_end, pk_clear, pk_valid;
  logic [DATA_WIDTH-1:0] pk_word;

  assign vs_rise = vsync & ~vsync_prev_q;
  assign de_fall = de_prev_q & ~de;
  assign active  = (state_q == S_ACTIVE);
  assign in_x    = (int'(x_q) >= X_OFFSET) && (int'(x_q) < X_END);
  assign in_y    = (int'(y_q) >= Y_OFFSET) && (int'(y_q) < Y_END);
  // A vsync edge pre-empts everything else in its cycle, including a completing word.
  assign take_px  = active && de && in_x && in_y && !vs_rise;
  assign line_end = active && de_fall && in_y && !vs_rise;
  assign pk_clear = vs_rise || line_end;

  fb_pixel_packer #(.DATA_WIDTH(DATA_WIDTH)) u_packer (
    .clk          (clk),
    .reset        (reset),
    .clear_i      (pk_clear),
    .shift_i      (take_px),
    .pixel_i      (pixel),
    .word_valid_o (pk_valid),
    .word_o       (pk_word)
  );

  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    row_base_d   = row_base_q;
    word_idx_d   = word_idx_q;
    wr_enable_d  = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    frame_done_d = 1'b0;
    if (vs_rise) begin
      state_d    = enable ? S_ACTIVE : S_WAIT;
      x_d        = '0;
      y_d        = '0;
      row_base_d = '0;
      word_idx_d = '0;
    end else if (active) begin
      // Counters stick at all-ones so an overlong line/frame never re-enters the window.
      if (de) x_d = (x_q == '1) ? x_q : x_q + 1'b1;
      else    x_d = '0;
      if (de_fall && (y_q != '1)) y_d = y_q + 1'b1;
      if (pk_valid) begin
        wr_enable_d = 1'b1;
        wr_addr_d   = row_base_q + word_idx_q;
        wr_data_d   = pk_word;
        word_idx_d  = word_idx_q + 1'b1;
      end
      if (line_end) begin
        row_base_d = row_base_q + ROW_STEP;
        word_idx_d = '0;
        if (y_q == Y_LAST) begin
          state_d      = S_WAIT;
          frame_done_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_WAIT;
      vsync_prev_q <= 1'b0;
      de_prev_q    <= 1'b0;
      x_q          <= '0;
      y_q          <= '0;
      row_base_q   <= '0;
      word_idx_q   <= '0;
      wr_enable_q  <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      vsync_prev_q <= vsync;
      de_prev_q    <= de;
      x_q          <= x_d;
      y_q          <= y_d;
      row_base_q   <= row_base_d;
      word_idx_q   <= word_idx_d;
      wr_enable_q  <= wr_enable_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign wr_enable  = wr_enable_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign frame_done = frame_done_q;
  assign busy       = active;

endmodule

// File: tb/tb_fb_writer.sv
// Randomized bench for fb_writer; expected writes come from a per-pixel window/word model.
module tb_fb_writer;

  localparam int AW = 2, DW = 8, FBW = 16, FBH = 2, XO = 2, YO = 1;
  localparam int WPL = FBW / DW;

  logic clk = 1'b0;
  logic reset, enable, vsync, de, pixel;
  logic wr_enable, frame_done, busy;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;

  fb_writer #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FB_WIDTH(FBW), .FB_HEIGHT(FBH),
    .X_OFFSET(XO), .Y_OFFSET(YO), .COUNT_WIDTH(12)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .vsync(vsync), .de(de), .pixel(pixel),
    .wr_enable(wr_enable), .wr_addr(wr_addr), .wr_data(wr_data),
    .frame_done(frame_done), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0, cyc = 0;
  logic [AW-1:0] obs_addr[$], exp_addr[$];
  logic [DW-1:0] obs_data[$], exp_data[$];
  int obs_cyc[$], exp_cyc[$], obs_fd[$];
  int exp_fd, busy_cnt;
  int nlines;
  int line_len[6];
  bit pix[6][32];

  // One pixel-clock cycle: drive, let the edge pass, then log what the outputs show.
  task automatic step(input logic v, input logic d, input logic p);
    vsync = v; de = d; pixel = p;
    @(posedge clk); #1;
    cyc++;
    if (wr_enable === 1'b1) begin
      obs_addr.push_back(wr_addr); obs_data.push_back(wr_data); obs_cyc.push_back(cyc);
    end
    if (frame_done === 1'b1) obs_fd.push_back(cyc);
    if (busy === 1'b1) busy_cnt++;
  endtask

  task automatic clear_logs();
    obs_addr.delete(); obs_data.delete(); obs_cyc.delete(); obs_fd.delete();
    exp_addr.delete(); exp_data.delete(); exp_cyc.delete();
    exp_fd = -1; busy_cnt = 0;
  endtask

  // Reference: a pixel that is the DW-th of its word inside the window produces a write
  // visible right after its sampling edge, at address (line-in-window)*WPL + word-in-line.
  task automatic model_pixel(input int l, input int x);
    logic [DW-1:0] w;
    if (l >= YO && l < YO + FBH && x >= XO && x < XO + FBW && ((x - XO) % DW) == DW - 1) begin
      w = '0;
      for (int k = x - DW + 1; k <= x; k++) w = {w[DW-2:0], pix[l][k]};
      exp_addr.push_back(AW'((l - YO) * WPL + (x - XO) / DW));
      exp_data.push_back(w);
      exp_cyc.push_back(cyc);
    end
  endtask

  task automatic fill_pattern(input int n, input int len);
    nlines = n;
    for (int l = 0; l < n; l++) begin
      line_len[l] = len;
      for (int x = 0; x < 32; x++) pix[l][x] = (x % 2 == 0);
    end
  endtask

  task automatic fill_random(input int n, input int lo, input int hi);
    nlines = n;
    for (int l = 0; l < n; l++) begin
      line_len[l] = $urandom_range(hi, lo);
      for (int x = 0; x < 32; x++) pix[l][x] = $urandom_range(1, 0) == 1;
    end
  endtask

  task automatic drive_line(input int l, input int from, input int to);
    for (int x = from; x < to; x++) step(1'b0, 1'b1, pix[l][x]);
  endtask

  task automatic play_frame(input bit en);
    clear_logs();
    enable = en;
    step(0, 0, 0); step(1, 0, 0); step(0, 0, 0);
    for (int l = 0; l < nlines; l++) begin
      for (int x = 0; x < line_len[l]; x++) begin
        step(1'b0, 1'b1, pix[l][x]);
        if (en) model_pixel(l, x);
      end
      step(0, 0, 0);
      if (en && l == YO + FBH - 1) exp_fd = cyc;
      step(0, 0, 0);
    end
    step(0, 0, 0);
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b0; vsync = 1'b0; de = 1'b0; pixel = 1'b0;
    step(0, 0, 0); step(0, 0, 0);
    checks++;
    if (wr_enable !== 1'b0 || wr_addr !== '0 || wr_data !== '0 || frame_done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got we=%b addr=%0d data=%h fd=%b busy=%b, expected all 0",
               wr_enable, wr_addr, wr_data, frame_done, busy);
    end
    reset = 1'b0;
    step(0, 0, 0);
  endtask

  task automatic test_full_frame();
    fill_pattern(4, 20);
    play_frame(1'b1);
    checks++;
    if (obs_addr.size() != 4) begin
      errors++; $display("FAIL full_frame_count: got %0d writes, expected 4", obs_addr.size());
    end
    for (int i = 0; i < obs_addr.size() && i < 4; i++) begin
      checks++;
      if (obs_addr[i] !== AW'(i) || obs_data[i] !== 8'hAA) begin
        errors++;
        $display("FAIL full_frame_word%0d: got addr=%0d data=%h, expected addr=%0d data=aa",
                 i, obs_addr[i], obs_data[i], i);
      end
    end
    checks++;
    if (obs_fd.size() != 1 || obs_fd[0] != exp_fd) begin
      errors++; $display("FAIL full_frame_done: got %0d pulses, expected 1 at cycle %0d", obs_fd.size(), exp_fd);
    end
  endtask

  task automatic test_latency();
    fill_random(4, 20, 20);
    play_frame(1'b1);
    checks++;
    if (obs_cyc.size() != exp_cyc.size()) begin
      errors++; $display("FAIL latency_count: got %0d writes, expected %0d", obs_cyc.size(), exp_cyc.size());
    end else begin
      for (int i = 0; i < obs_cyc.size(); i++) begin
        checks++;
        if (obs_cyc[i] != exp_cyc[i] || obs_addr[i] !== exp_addr[i] || obs_data[i] !== exp_data[i]) begin
          errors++;
          $display("FAIL latency_word%0d: got cyc=%0d addr=%0d data=%h, expected cyc=%0d addr=%0d data=%h",
                   i, obs_cyc[i], obs_addr[i], obs_data[i], exp_cyc[i], exp_addr[i], exp_data[i]);
        end
      end
    end
    for (int i = 1; i < obs_cyc.size(); i++) begin
      checks++;
      if (obs_cyc[i] - obs_cyc[i-1] < DW) begin
        errors++; $display("FAIL write_spacing: writes %0d cycles apart, expected >= %0d", obs_cyc[i] - obs_cyc[i-1], DW);
      end
    end
  endtask

  task automatic test_short_line();
    fill_random(4, 20, 20);
    line_len[1] = 14;
    play_frame(1'b1);
    checks++;
    if (obs_addr.size() != 3 || obs_addr[0] !== 2'd0 || obs_addr[1] !== 2'd2 || obs_addr[2] !== 2'd3) begin
      errors++; $display("FAIL short_line_addrs: got %0d writes (first addr %0d), expected addrs 0,2,3",
                         obs_addr.size(), obs_addr.size() > 0 ? obs_addr[0] : 0);
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (obs_data[i] !== exp_data[i] || obs_cyc[i] != exp_cyc[i]) begin
          errors++; $display("FAIL short_line_word%0d: got data=%h cyc=%0d, expected data=%h cyc=%0d",
                             i, obs_data[i], obs_cyc[i], exp_data[i], exp_cyc[i]);
        end
      end
    end
    checks++;
    if (obs_fd.size() != 1 || obs_fd[0] != exp_fd) begin
      errors++; $display("FAIL short_line_done: got %0d pulses, expected 1", obs_fd.size());
    end
  endtask

  task automatic test_freeze();
    fill_pattern(4, 20);
    play_frame(1'b0);
    checks++;
    if (obs_addr.size() != 0 || obs_fd.size() != 0 || busy_cnt != 0) begin
      errors++; $display("FAIL freeze: got writes=%0d done=%0d busy_cycles=%0d, expected all 0",
                         obs_addr.size(), obs_fd.size(), busy_cnt);
    end
    play_frame(1'b1);
    checks++;
    if (obs_addr.size() != 4 || obs_fd.size() != 1) begin
      errors++; $display("FAIL freeze_followup: got writes=%0d done=%0d, expected 4 and 1", obs_addr.size(), obs_fd.size());
    end
  endtask

  task automatic test_midframe_vsync();
    fill_random(4, 20, 20);
    clear_logs();
    enable = 1'b1;
    step(0, 0, 0); step(1, 0, 0); step(0, 0, 0);
    drive_line(0, 0, 20); step(0, 0, 0); step(0, 0, 0);
    drive_line(1, 0, XO + 3);
    step(1, 0, 0); step(0, 0, 0); step(0, 0, 0); step(0, 0, 0);
    checks++;
    if (obs_addr.size() != 0 || obs_fd.size() != 0) begin
      errors++; $display("FAIL midframe_abort: got writes=%0d done=%0d, expected 0 and 0", obs_addr.size(), obs_fd.size());
    end
    // vsync rising on the very cycle the 8th window pixel is sampled
    clear_logs();
    step(0, 0, 0); step(1, 0, 0); step(0, 0, 0);
    drive_line(0, 0, 20); step(0, 0, 0); step(0, 0, 0);
    drive_line(1, 0, XO + DW - 1);
    step(1'b1, 1'b1, pix[1][XO + DW - 1]);
    step(0, 0, 0); step(0, 0, 0);
    checks++;
    if (obs_addr.size() != 0) begin
      errors++; $display("FAIL vsync_wins: got %0d writes, expected 0", obs_addr.size());
    end
    play_frame(1'b1);
    checks++;
    if (obs_addr.size() != exp_addr.size() || obs_addr.size() == 0 || obs_addr[0] !== 2'd0 || obs_data[0] !== exp_data[0]) begin
      errors++; $display("FAIL midframe_restart: got %0d writes (first addr %0d), expected %0d from addr 0",
                         obs_addr.size(), obs_addr.size() > 0 ? obs_addr[0] : 0, exp_addr.size());
    end
  endtask

  task automatic test_async_reset();
    nlines = 4;
    for (int l = 0; l < 4; l++) begin
      line_len[l] = 20;
      for (int x = 0; x < 32; x++) pix[l][x] = 1'b1;
    end
    clear_logs();
    enable = 1'b1;
    step(0, 0, 0); step(1, 0, 0); step(0, 0, 0);
    drive_line(0, 0, 20); step(0, 0, 0); step(0, 0, 0);
    drive_line(1, 0, 12);
    checks++;
    if (obs_addr.size() != 1 || wr_data !== 8'hFF || busy !== 1'b1) begin
      errors++; $display("FAIL pre_reset_state: got writes=%0d data=%h busy=%b, expected 1, ff, 1", obs_addr.size(), wr_data, busy);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (wr_enable !== 1'b0 || wr_addr !== '0 || wr_data !== '0 || frame_done !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL async_reset: got we=%b addr=%0d data=%h fd=%b busy=%b, expected all 0",
                         wr_enable, wr_addr, wr_data, frame_done, busy);
    end
    #2 reset = 1'b0;
    clear_logs();
    drive_line(1, 12, 20); step(0, 0, 0); step(0, 0, 0);
    for (int l = 2; l < 4; l++) begin
      drive_line(l, 0, 20); step(0, 0, 0); step(0, 0, 0);
    end
    checks++;
    if (obs_addr.size() != 0 || obs_fd.size() != 0 || busy_cnt != 0) begin
      errors++; $display("FAIL post_reset_idle: got writes=%0d done=%0d busy_cycles=%0d, expected all 0",
                         obs_addr.size(), obs_fd.size(), busy_cnt);
    end
    fill_random(4, 20, 20);
    play_frame(1'b1);
    checks++;
    if (obs_addr.size() != 4 || obs_fd.size() != 1) begin
      errors++; $display("FAIL post_reset_capture: got writes=%0d done=%0d, expected 4 and 1", obs_addr.size(), obs_fd.size());
    end
  endtask

  task automatic test_back_to_back();
    for (int f = 0; f < 8; f++) begin
      fill_random($urandom_range(5, 3), 1, 24);
      play_frame($urandom_range(3, 0) != 0);
      checks++;
      if (obs_addr.size() != exp_addr.size()) begin
        errors++; $display("FAIL b2b_f%0d_count: got %0d writes, expected %0d", f, obs_addr.size(), exp_addr.size());
      end else begin
        for (int i = 0; i < obs_addr.size(); i++) begin
          checks++;
          if (obs_addr[i] !== exp_addr[i] || obs_data[i] !== exp_data[i] || obs_cyc[i] != exp_cyc[i]) begin
            errors++;
            $display("FAIL b2b_f%0d_word%0d: got addr=%0d data=%h cyc=%0d, expected addr=%0d data=%h cyc=%0d",
                     f, i, obs_addr[i], obs_data[i], obs_cyc[i], exp_addr[i], exp_data[i], exp_cyc[i]);
          end
        end
      end
      checks++;
      if ((exp_fd < 0) ? (obs_fd.size() != 0) : (obs_fd.size() != 1 || obs_fd[0] != exp_fd)) begin
        errors++; $display("FAIL b2b_f%0d_done: got %0d pulses, expected cycle %0d (-1 = none)", f, obs_fd.size(), exp_fd);
      end
    end
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_latency();
    test_short_line();
    test_freeze();
    test_midframe_vsync();
    test_async_reset();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fb_writer.md
Name: fb_writer

Overview:
- Upstream feeder of the dual-clock framebuffer RAM: runs in the capture pixel-clock domain and drives its write port.
- Takes a decoded 1-bit-per-pixel video stream (de, vsync, pixel) and crops a fixed window from it.
- Packs DATA_WIDTH consecutive pixels into one word and emits wr_enable/wr_addr/wr_data with linear row-major addressing.
- Optional frame freeze via enable; frame_done pulses when a full window has been stored.

Parameters:
- ADDR_WIDTH, 13, framebuffer word-address width; must equal the RAM's ADDR_WIDTH.
- DATA_WIDTH, 8, pixels per word; must equal the RAM's DATA_WIDTH.
- FB_WIDTH, 256, window width in pixels; must be a multiple of DATA_WIDTH.
- FB_HEIGHT, 256, window height in lines; (FB_WIDTH/DATA_WIDTH)*FB_HEIGHT <= 2**ADDR_WIDTH.
- X_OFFSET, 0, first captured pixel index within a line.
- Y_OFFSET, 0, first captured line index after vsync.
- COUNT_WIDTH, 12, width of the raw x/y counters.

Ports:
- clk  in  1  pixel clock; all inputs synchronous to it.
- reset  in  1  asynchronous, active-high.
- enable  in  1  capture enable, sampled only at vsync rising edge.
- vsync  in  1  frame sync; rising edge starts a frame.
- de  in  1  data enable; high for each active pixel.
- pixel  in  1  pixel value, valid when de=1.
- wr_enable  out  1  one-cycle RAM write strobe.
- wr_addr  out  ADDR_WIDTH  RAM word address.
- wr_data  out  DATA_WIDTH  packed pixels.
- frame_done  out  1  one-cycle pulse after the last word of the window is written.
- busy  out  1  high while in S_ACTIVE.

Behaviour:
- Reset: state=S_WAIT; wr_enable=0, wr_addr=0, wr_data=0, frame_done=0, busy=0; all counters and shift register cleared; vsync_prev=0.
- Reset deasserted mid-line: no write until after the next vsync rising edge.
- vsync rising edge (vsync=1 & vsync_prev=0), from any state:
  - enable=1: enter S_ACTIVE and clear x, y, shift register, word count and row_base.
  - enable=0: enter S_WAIT.
  - Abort mid-frame: discard any partial word; no frame_done.
- S_WAIT: ignore de/pixel; no writes.
- S_ACTIVE, x counter: increments each de=1 cycle and clears on the cycle after de falls.
- S_ACTIVE, y counter: increments on each de falling edge.
- Window: x in [X_OFFSET, X_OFFSET+FB_WIDTH) and y in [Y_OFFSET, Y_OFFSET+FB_HEIGHT). Pixels outside it are dropped.
- Packing: first window pixel of a word lands in bit DATA_WIDTH-1 (MSB-first); the shift register shifts left.
- Word output: on the cycle the DATA_WIDTH-th pixel of a word is sampled (cycle N):
  - cycle N+1: wr_enable=1, wr_data=packed word, wr_addr=row_base+word_idx.
  - word_idx then increments; wr_enable is 0 otherwise.
  - wr_addr/wr_data hold their last values when wr_enable=0.
- Line end inside the window (de falls):
  - row_base += FB_WIDTH/DATA_WIDTH; word_idx=0.
  - Partial word (short input line) is discarded, never written.
- Last line: when the de falling edge ends line Y_OFFSET+FB_HEIGHT-1, go to S_WAIT.
  - frame_done=1 on the cycle after that edge; the final word's write is therefore already complete.
- Widths: row_base+word_idx is computed in ADDR_WIDTH bits; no wrap within a legal frame.
  - Counters saturate at all-ones; no wrap into the window.
- Simultaneous events: vsync edge in the same cycle as a word completion → vsync wins; the word is not written.
- Throughput: a write is possible at most every DATA_WIDTH cycles, so the RAM never sees back-to-back writes.

Decomposition:
- fb_pkg: WORDS_PER_LINE = FB_WIDTH/DATA_WIDTH, state encoding (S_WAIT, S_ACTIVE), and an elaboration-time legality check on the parameters.
- Sub-module: fb_pixel_packer (shift register plus count; emits word_valid/word).
- fb_writer itself holds the sync edge detection, x/y counters, window compare, addressing and FSM.

Test Plan (bench params DATA_WIDTH=8, FB_WIDTH=16, FB_HEIGHT=2, X_OFFSET=2, Y_OFFSET=1, ADDR_WIDTH=2):
- Full frame:
  - Stimulus: enable=1, vsync pulse, then 4 lines of 20 de-cycles each, with the pixel pattern alternating 1,0 from x=0.
  - Response: 4 writes, each with wr_data=8'hAA, at addresses 0,1 (line 1) and 2,3 (line 2); frame_done pulses once after line 2.
  - Check: no writes for line 0 or line 3.
- Latency:
  - Stimulus: the 8th window pixel is sampled at cycle N.
  - Response: wr_enable=1 at exactly N+1 for one cycle only.
- Freeze:
  - Stimulus: enable=0 at the vsync edge, then the full frame.
  - Response: zero writes, busy=0, frame_done=0.
  - Follow-up: enable=1 at the next vsync → normal capture.
- Mid-frame vsync:
  - Stimulus: vsync edge after 3 pixels of window line 1.
  - Response: no write and no frame_done; the next frame restarts at address 0.
- Short line:
  - Stimulus: window line 1 is only 14 pixels wide (de falls after x=13).
  - Response: address 0 is written; the partial word is dropped; line 2 writes start at address 2.
- Async reset:
  - Stimulus: reset asserted between clock edges mid-line.
  - Response: outputs go to 0 immediately; no write until after the next vsync rising edge.
